// File: rtl/uart_alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_alu_ctrl_pkg
// Shared definitions for the UART/ALU frame sequencer and its neighbours at
// the top level (RX FIFO, ALU, TX FIFO):
//   - default data width N_DEF and opcode width NB_OP_DEF
//   - 3-bit state encoding constants and the matching state enum
//   - small helper to classify the byte-collecting states
// -----------------------------------------------------------------------------
package uart_alu_ctrl_pkg;

    // Default widths, shared with the FIFO and ALU instances at the top level.
    localparam int N_DEF     = 8;
    localparam int NB_OP_DEF = 6;

    // State encoding.
    localparam logic [2:0] ST_GET_A  = 3'd0;
    localparam logic [2:0] ST_GET_B  = 3'd1;
    localparam logic [2:0] ST_GET_OP = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_SEND   = 3'd4;

    typedef enum logic [2:0] {
        GET_A  = ST_GET_A,
        GET_B  = ST_GET_B,
        GET_OP = ST_GET_OP,
        EXEC   = ST_EXEC,
        SEND   = ST_SEND
    } state_e;

    // True in the three states that pop one byte from the RX FIFO.
    function automatic logic is_rx_state(input state_e s);
        return (s == GET_A) || (s == GET_B) || (s == GET_OP);
    endfunction

endpackage : uart_alu_ctrl_pkg

// File: rtl/uart_alu_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_alu_ctrl_if
// Bundles the three handshakes around the frame sequencer:
//   RX FIFO read port : rx_empty, rx_data (to ctrl), rx_rd (from ctrl)
//   ALU               : alu_a, alu_b, alu_op (from ctrl), alu_result (to ctrl)
//   TX FIFO write port: tx_full (to ctrl), tx_wr, tx_data (from ctrl)
// Modports:
//   master - the sequencer (sole master of both FIFO handshakes)
//   slave  - the FIFO/ALU side
// -----------------------------------------------------------------------------
interface uart_alu_ctrl_if
    import uart_alu_ctrl_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int NB_OP = NB_OP_DEF
) ();

    // RX FIFO read port
    logic             rx_empty;
    logic [N-1:0]     rx_data;
    logic             rx_rd;

    // ALU
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [NB_OP-1:0] alu_op;
    logic [N-1:0]     alu_result;

    // TX FIFO write port
    logic             tx_full;
    logic             tx_wr;
    logic [N-1:0]     tx_data;

    modport master (
        input  rx_empty, rx_data, alu_result, tx_full,
        output rx_rd, alu_a, alu_b, alu_op, tx_wr, tx_data
    );

    modport slave (
        output rx_empty, rx_data, alu_result, tx_full,
        input  rx_rd, alu_a, alu_b, alu_op, tx_wr, tx_data
    );

endinterface : uart_alu_ctrl_if

// File: rtl/uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// uart_alu_ctrl
// Frame sequencer: pops operand A, operand B and an opcode byte from the RX
// FIFO, holds them on the ALU inputs, captures the ALU result one cycle later
// and pushes it as one byte into the TX FIFO. With both FIFOs ready a frame
// takes five cycles (3 pops, EXEC, push).
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-high reset
//   bus       --   uart_alu_ctrl_if.master (RX read port, ALU, TX write port)
//   busy      out  registered, high whenever the FSM is outside GET_A
//   frame_cnt out  completed-frame counter, wraps modulo 2^NB_CNT
// -----------------------------------------------------------------------------
module uart_alu_ctrl
    import uart_alu_ctrl_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int NB_OP  = NB_OP_DEF,
    parameter int NB_CNT = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_alu_ctrl_if.master   bus,
    output logic              busy,
    output logic [NB_CNT-1:0] frame_cnt
);

    state_e            state_q, state_d;
    logic [N-1:0]      a_q, a_d;
    logic [N-1:0]      b_q, b_d;
    logic [NB_OP-1:0]  op_q, op_d;
    logic [N-1:0]      res_q, res_d;
    logic [NB_CNT-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    // Ungated strobes; the gated versions below are what leave the block.
    logic              rx_rd;
    logic              tx_wr;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        cnt_d   = cnt_q;

        // Mealy strobes: a pop only when the head word is valid, a push only
        // when there is room, so neither FIFO ever sees an illegal access.
        rx_rd   = is_rx_state(state_q) & ~bus.rx_empty;
        tx_wr   = (state_q == SEND) & ~bus.tx_full;

        unique case (state_q)
            GET_A: begin
                if (rx_rd) begin
                    a_d     = bus.rx_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (rx_rd) begin
                    b_d     = bus.rx_data;
                    state_d = GET_OP;
                end
            end
            GET_OP: begin
                if (rx_rd) begin
                    // Opcode byte bits above NB_OP-1 are dropped here.
                    op_d    = bus.rx_data[NB_OP-1:0];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // The ALU has had this whole cycle with stable operands.
                res_d   = bus.alu_result;
                state_d = SEND;
            end
            SEND: begin
                if (tx_wr) begin
                    cnt_d   = cnt_q + NB_CNT'(1);
                    state_d = GET_A;
                end
            end
            default: begin
                state_d = GET_A;
            end
        endcase

        busy_d = (state_d != GET_A);
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: all datapath registers are reset, not just the FSM, so the ALU
    // inputs and tx_data are defined (zero) straight out of reset and a
    // partially collected frame leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Strobes are forced low during reset so no pop or push can coincide
    // with the reset edge.
    assign bus.rx_rd   = rx_rd & ~reset;
    assign bus.tx_wr   = tx_wr & ~reset;

    assign bus.alu_a   = a_q;
    assign bus.alu_b   = b_q;
    assign bus.alu_op  = op_q;
    assign bus.tx_data = res_q;

    assign busy        = busy_q;
    assign frame_cnt   = cnt_q;

endmodule : uart_alu_ctrl

// File: tb/tb_uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_ctrl
// Self-checking bench for uart_alu_ctrl. The RX FIFO, TX FIFO and ALU are
// modelled with queues and a function; expected results come from grouping
// popped bytes into frames (discarding partial frames on reset) and applying
// the ALU function to each frame. A second DUT with a 2-bit frame counter
// runs in lock-step on the same inputs to exercise counter wrap.
// -----------------------------------------------------------------------------
module tb_uart_alu_ctrl;
    import uart_alu_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        busy_w;
    logic [1:0]  frame_cnt_w;

    uart_alu_ctrl_if ifm ();
    uart_alu_ctrl_if ifw ();

    uart_alu_ctrl #(.NB_CNT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (ifm),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    uart_alu_ctrl #(.NB_CNT(2)) dut_w (
        .clk       (clk),
        .reset     (reset),
        .bus       (ifw),
        .busy      (busy_w),
        .frame_cnt (frame_cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ALU model ----------------
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            6'h03:   return $unsigned($signed(a) >>> b[2:0]);
            default: return 8'h00;
        endcase
    endfunction

    assign ifm.alu_result = alu_fn(ifm.alu_a, ifm.alu_b, ifm.alu_op);
    assign ifw.alu_result = alu_fn(ifw.alu_a, ifw.alu_b, ifw.alu_op);
    assign ifw.rx_empty   = ifm.rx_empty;
    assign ifw.rx_data    = ifm.rx_data;
    assign ifw.tx_full    = ifm.tx_full;

    // ---------------- FIFO models and scoreboard state ----------------
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] expq[$];
    logic [7:0] frame_bytes[$];
    int         pop_edges[$];
    int         push_edges[$];
    int         cyc     = 0;
    int         viol_rx = 0;
    int         viol_tx = 0;
    int         n_pass  = 0;
    int         n_total = 0;
    logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

    task automatic upd_rx();
        ifm.rx_empty = (rxq.size() == 0);
        ifm.rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
    endtask

    // Observes the handshakes at each edge; FIFO state moves 1 time unit
    // later so the DUT samples the pre-edge head word.
    always @(posedge clk) begin
        logic       rd, wr;
        logic [7:0] rdd, wrd;
        cyc++;
        rd  = ifm.rx_rd;
        wr  = ifm.tx_wr;
        rdd = ifm.rx_data;
        wrd = ifm.tx_data;
        if (rd && ifm.rx_empty) viol_rx++;
        if (wr && ifm.tx_full)  viol_tx++;
        if (rd) begin
            pop_edges.push_back(cyc);
            frame_bytes.push_back(rdd);
            if (frame_bytes.size() == 3) begin
                expq.push_back(alu_fn(frame_bytes[0], frame_bytes[1], frame_bytes[2][5:0]));
                frame_bytes.delete();
            end
        end
        if (wr) begin
            push_edges.push_back(cyc);
            txq.push_back(wrd);
        end
        #1;
        if (rd && rxq.size() > 0) void'(rxq.pop_front());
        upd_rx();
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        rxq.push_back(b);
        upd_rx();
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        push_byte(a);
        push_byte(b);
        push_byte(op);
    endtask

    task automatic push_rand_frame();
        logic [7:0] opb;
        opb = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
        push_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), opb);
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int k = 0;
        while (pop_edges.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_pops"}, pop_edges.size(), n);
    endtask

    task automatic wait_pushes(input int n, input int budget, input string tag);
        int k = 0;
        while (push_edges.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_pushes"}, push_edges.size(), n);
    endtask

    task automatic drain(input string tag);
        check({tag, "_npush"}, txq.size(), expq.size());
        while (txq.size() > 0 && expq.size() > 0)
            check({tag, "_data"}, txq.pop_front(), expq.pop_front());
        txq.delete();
        expq.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int bad_wr;
        int bad_data;

        reset       = 1'b1;
        ifm.tx_full = 1'b0;
        upd_rx();

        // Reset with both FIFOs empty.
        repeat (3) @(negedge clk);
        check("rst_busy",    busy,        0);
        check("rst_rx_rd",   ifm.rx_rd,   0);
        check("rst_tx_wr",   ifm.tx_wr,   0);
        check("rst_cnt",     frame_cnt,   0);
        check("rst_alu_a",   ifm.alu_a,   0);
        check("rst_alu_b",   ifm.alu_b,   0);
        check("rst_alu_op",  ifm.alu_op,  0);
        check("rst_tx_data", ifm.tx_data, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy",   busy,        0);
        check("idle_rx_rd",  ifm.rx_rd,   0);

        // Single frame 5 + 3 (add) = 8.
        push_frame(8'h05, 8'h03, 8'h20);
        wait_pops(3, 20, "f1");
        wait_pushes(1, 20, "f1");
        check("f1_pop_gap1", pop_edges[1] - pop_edges[0], 1);
        check("f1_pop_gap2", pop_edges[2] - pop_edges[1], 1);
        check("f1_push_lat", push_edges[0] - pop_edges[2], 2);
        check("f1_result",   txq[0], 8'h08);
        @(negedge clk);
        check("f1_cnt",      frame_cnt, 1);
        check("f1_busy",     busy, 0);
        drain("f1");

        // Starved RX: bytes 10 cycles apart.
        push_byte(8'hAC);
        wait_pops(4, 20, "st_a");
        check("st_busy_a", busy, 1);
        repeat (10) @(negedge clk);
        check("st_hold_a", pop_edges.size(), 4);
        check("st_busy_a2", busy, 1);
        push_byte(8'h0F);
        wait_pops(5, 20, "st_b");
        repeat (10) @(negedge clk);
        check("st_hold_b", pop_edges.size(), 5);
        check("st_busy_b", busy, 1);
        push_byte(8'h25);
        wait_pops(6, 20, "st_op");
        check("st_busy_op", busy, 1);
        wait_pushes(2, 20, "st");
        check("st_result", txq[0], 8'hAF);
        check("st_busy_end", busy, 0);
        check("st_cnt", frame_cnt, 2);
        drain("st");

        // TX back-pressure at SEND for 20 cycles.
        ifm.tx_full = 1'b1;
        push_frame(8'h40, 8'h30, 8'h22);
        wait_pops(9, 20, "bp");
        @(negedge clk);
        bad_wr   = 0;
        bad_data = 0;
        repeat (20) begin
            if (ifm.tx_wr !== 1'b0)     bad_wr++;
            if (ifm.tx_data !== 8'h10) bad_data++;
            @(negedge clk);
        end
        check("bp_no_wr",      bad_wr,   0);
        check("bp_data_hold",  bad_data, 0);
        check("bp_no_push",    push_edges.size(), 2);
        check("bp_busy",       busy, 1);
        ifm.tx_full = 1'b0;
        @(negedge clk);
        check("bp_one_push",   push_edges.size(), 3);
        check("bp_busy_idle",  busy, 0);
        repeat (3) @(negedge clk);
        check("bp_no_extra",   push_edges.size(), 3);
        check("bp_cnt",        frame_cnt, 3);
        drain("bp");

        // Streaming: 4 frames preloaded; last opcode byte 0xE0 -> add.
        repeat (3) push_rand_frame();
        push_frame(8'h11, 8'h22, 8'hE0);
        wait_pops(21, 80, "sm");
        wait_pushes(7, 80, "sm");
        for (int i = 3; i < 6; i++)
            check("sm_push_gap", push_edges[i+1] - push_edges[i], 5);
        @(negedge clk);
        check("sm_cnt",    frame_cnt,   7);
        check("sm_cnt_w",  frame_cnt_w, 3);
        check("sm_alu_op", ifm.alu_op,  6'h20);
        check("sm_alu_a",  ifm.alu_a,   8'h11);
        check("sm_alu_b",  ifm.alu_b,   8'h22);
        check("sm_last",   txq[3],      8'h33);
        drain("sm");

        // Reset after two pops of a frame.
        push_byte(8'h55);
        push_byte(8'h66);
        wait_pops(23, 20, "mr");
        reset = 1'b1;
        frame_bytes.delete();
        #1;
        check("mr_busy",    busy,        0);
        check("mr_tx_wr",   ifm.tx_wr,   0);
        check("mr_alu_a",   ifm.alu_a,   0);
        check("mr_alu_b",   ifm.alu_b,   0);
        check("mr_cnt",     frame_cnt,   0);
        check("mr_tx_data", ifm.tx_data, 0);
        push_frame(8'h09, 8'h04, 8'h20);
        #1;
        check("mr_rd_gated", ifm.rx_rd, 0);
        repeat (2) @(negedge clk);
        check("mr_no_pop", pop_edges.size(), 23);
        reset = 1'b0;
        wait_pops(26, 20, "mr2");
        wait_pushes(8, 20, "mr2");
        check("mr_result", txq[0], 8'h0D);
        @(negedge clk);
        check("mr_cnt2", frame_cnt, 1);
        drain("mr");

        // Counter wrap on the 2-bit instance: 5 frames since reset.
        repeat (4) push_rand_frame();
        wait_pops(38, 80, "wr");
        wait_pushes(12, 80, "wr");
        @(negedge clk);
        check("wr_cnt",   frame_cnt,   5);
        check("wr_cnt_w", frame_cnt_w, 1);
        drain("wr");

        check("rx_rd_when_empty", viol_rx, 0);
        check("tx_wr_when_full",  viol_tx, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_uart_alu_ctrl

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Frame sequencer between the UART receive FIFO, the ALU and the UART transmit FIFO. It pops three bytes per frame from the RX FIFO (operand A, operand B, opcode) and presents them to the ALU. It then registers the ALU result and pushes it as one byte into the TX FIFO. It sits at the top level between the RX FIFO read port, the ALU and the TX FIFO write port, and is the only master of both FIFO handshakes.

## Interface
- N, 8, data/operand width in bits; equals the FIFO word width.
- NB_OP, 6, opcode width; taken from bits [NB_OP-1:0] of the third byte.
- NB_CNT, 16, width of the completed-frame counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- rx_empty  in  1  RX FIFO empty flag.
- rx_data  in  N  RX FIFO head word; combinational, valid whenever rx_empty=0.
- rx_rd  out  1  RX FIFO pop strobe.
- alu_a  out  N  operand A register.
- alu_b  out  N  operand B register.
- alu_op  out  NB_OP  opcode register.
- alu_result  in  N  combinational ALU result.
- tx_full  in  1  TX FIFO full flag.
- tx_wr  out  1  TX FIFO push strobe.
- tx_data  out  N  result register, driven to the TX FIFO write data.
- busy  out  1  high when the state is not GET_A.
- frame_cnt  out  NB_CNT  number of completed frames, wraps modulo 2^NB_CNT.

## Operation
- States: GET_A, GET_B, GET_OP, EXEC, SEND. Reset state is GET_A.
- GET_A, GET_B, GET_OP:
  - rx_rd = ~rx_empty (Mealy). rx_rd is forced 0 while reset=1.
  - On a cycle with rx_rd=1, rx_data is captured into alu_a, alu_b or alu_op[NB_OP-1:0] respectively, and the FSM advances one state.
  - When rx_empty=1 the FSM holds state; rx_rd=0.
- EXEC: lasts one cycle, no handshake. The result register is loaded with alu_result; next state is SEND.
- SEND:
  - tx_wr = ~tx_full (Mealy); tx_data is the result register.
  - On a cycle with tx_wr=1: frame_cnt increments and the next state is GET_A.
  - When tx_full=1 the FSM holds; tx_wr=0 and the result register is unchanged.
- rx_rd is never asserted when rx_empty=1, and tx_wr is never asserted when tx_full=1. The block must never rely on the FIFOs' internal overflow/underflow protection.
- Opcode byte bits above NB_OP-1 are ignored.
- alu_a, alu_b and alu_op hold their values from capture until the next frame overwrites them.
- Reset values:
  - State GET_A; alu_a=0, alu_b=0, alu_op=0, result register=0, frame_cnt=0.
  - rx_rd=0, tx_wr=0, busy=0.
- Reset mid-frame: any partially collected frame is discarded. Bytes already popped are lost, and no byte is pushed for that frame.

## Timing
- Each pop or push occurs on the clock edge ending the cycle in which the strobe is high.
- Back-to-back pops are allowed. The FIFO updates rx_empty on the same edge as its pointer, so the flag is valid for the next cycle.
- With a non-empty RX FIFO and a non-full TX FIFO, a frame takes 5 cycles: 3 pops, 1 EXEC, 1 push.
- The opcode pop at edge k yields the result latched at edge k+1 and tx_wr=1 during cycle k+2.
- The ALU has one full cycle (the EXEC cycle) from alu_op settling to result capture.
- frame_cnt and busy are registered; they update on the edge that accepts the push.

## Structure
- Shared package holds:
  - The state encoding: 3-bit localparams ST_GET_A=0, ST_GET_B=1, ST_GET_OP=2, ST_EXEC=3, ST_SEND=4.
  - Default widths N and NB_OP, shared with the FIFO and ALU top-level instances.
- No sub-module. This is a single FSM with datapath registers.
- The FIFOs and ALU are instantiated beside this block at top level, not inside it.

## Test plan
- Reset with the FIFOs empty: all outputs are 0 and the state is GET_A. Push bytes 0x05, 0x03, 0x20 (add) into RX; the ALU model returns 0x08. Expect exactly three rx_rd pulses on consecutive cycles, then tx_wr during cycle k+2 with tx_data=0x08, and frame_cnt=1.
- Starved RX: bytes arrive 10 cycles apart. Expect rx_rd only when rx_empty=0, FSM holding between bytes, and busy=1 from the first pop until the push.
- TX back-pressure: hold tx_full=1 for 20 cycles at SEND. Expect tx_wr=0 throughout and tx_data stable. When tx_full drops, expect exactly one push and then a return to GET_A.
- Streaming: preload 12 bytes (4 frames). Expect 4 pushes, each 5 cycles apart, and frame_cnt=4. Opcode byte 0xE0 must produce alu_op=0x20.
- Reset asserted mid-frame after 2 pops: expect immediate return to GET_A with registers 0 and no tx_wr. The next 3 bytes in RX form a fresh frame.
- Counter wrap: with NB_CNT=2, run 5 frames and expect frame_cnt=1.
